// File: rtl/reaction_responder_if.sv
// Button/LED handshake between the reaction-timer game and its automated player.
// master = player (drives btn), slave = game (drives the LEDs).
interface reaction_responder_if;
  logic btn;
  logic led_set;
  logic led_go;

  modport master (output btn, input led_set, input led_go);
  modport slave  (input btn, output led_set, output led_go);
endinterface

// File: rtl/reaction_responder.sv
// Automated reaction-timer player: starts a trial, waits for "go", presses after react_ms ticks.
// Build option REACTION_RESPONDER_JITTER_EN adds LFSR jitter (0..15 ticks) to the reaction delay.
//
// state        | meaning
// IDLE         | waiting for enable with both LEDs dark
// START_PRESS  | holding btn to start a trial, watching for led_set
// WAIT_GO      | btn released, waiting for the led_go rise (bounded)
// REACT        | counting ticks of the latched reaction delay
// SCORE_PRESS  | holding btn to stop the timer, watching for led_go to drop
// DONE         | one-cycle trial completion
// ERROR        | protocol error, held until enable drops
module reaction_responder #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int TICK_HZ       = 1000,
  parameter int DELAY_W       = 10,
  parameter int PRESS_TICKS   = 20,
  parameter int TIMEOUT_TICKS = 2000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [DELAY_W-1:0]  react_ms,
  reaction_responder_if.master game,
  output logic                busy,
  output logic                trial_done,
  output logic [7:0]          trial_count,
  output logic [DELAY_W-1:0]  latency_ms,
  output logic                err
);

  localparam int PRESC_N = CLK_HZ / TICK_HZ;
  localparam int PW      = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
  localparam int CW      = DELAY_W + 4;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_N - 1);
  localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_TICKS - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_PRESS,
    S_WAIT_GO,
    S_REACT,
    S_SCORE_PRESS,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      presc_q;
  logic               tick;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc, cnt_p1;
  logic [DELAY_W-1:0] delay_q, delay_d, eff_delay, lat_d;
  logic               btn_q, btn_d;
  logic               seen_q, seen_d;
  logic               set_q, go_q, go_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign tick    = (presc_q == PRESC_LAST);
  assign go_rise = game.led_go & ~go_q;
  assign cnt_p1  = cnt_q + 1'b1;
  assign cnt_inc = (tick && (cnt_q != '1)) ? cnt_p1 : cnt_q;

`ifdef REACTION_RESPONDER_JITTER_EN
  logic [15:0]      lfsr_q;
  logic [DELAY_W:0] jit_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else if (state_q == S_DONE) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign jit_sum   = {1'b0, react_ms} + (DELAY_W+1)'(lfsr_q[3:0]);
  assign eff_delay = jit_sum[DELAY_W] ? '1 : jit_sum[DELAY_W-1:0];
`else
  assign eff_delay = react_ms;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    delay_d = delay_q;
    lat_d   = latency_ms;
    seen_d  = seen_q;
    case (state_q)
      S_IDLE: begin
        btn_d = 1'b0;
        if (enable && !game.led_set && !game.led_go) begin
          state_d = S_START_PRESS;
          cnt_d   = '0;
          btn_d   = 1'b1;
          seen_d  = 1'b0;
        end
      end
      S_START_PRESS: begin
        seen_d = seen_q | game.led_set;
        cnt_d  = cnt_inc;
        if (tick && cnt_q == PRESS_LAST) begin
          btn_d   = 1'b0;
          cnt_d   = '0;
          state_d = (seen_q | game.led_set) ? S_WAIT_GO : S_ERROR;
        end
      end
      S_WAIT_GO: begin
        cnt_d = cnt_inc;
        // a go rise beats a simultaneous set drop
        if (go_rise) begin
          delay_d = eff_delay;
          cnt_d   = '0;
          state_d = S_REACT;
        end else if (!game.led_set) begin
          state_d = S_ERROR;
        end else if (tick && cnt_q == TO_LAST) begin
          state_d = S_ERROR;
        end
      end
      S_REACT: begin
        cnt_d = cnt_inc;
        // fire on the tick that reaches the delay, or straight away for a zero delay
        if (cnt_q == {4'b0000, delay_q}) begin
          btn_d   = 1'b1;
          lat_d   = cnt_q[DELAY_W-1:0];
          cnt_d   = '0;
          seen_d  = 1'b0;
          state_d = S_SCORE_PRESS;
        end else if (tick && cnt_p1 == {4'b0000, delay_q}) begin
          btn_d   = 1'b1;
          lat_d   = cnt_p1[DELAY_W-1:0];
          cnt_d   = '0;
          seen_d  = 1'b0;
          state_d = S_SCORE_PRESS;
        end
      end
      S_SCORE_PRESS: begin
        seen_d = seen_q | ~game.led_go;
        cnt_d  = cnt_inc;
        if (tick && cnt_q == PRESS_LAST) begin
          btn_d   = 1'b0;
          cnt_d   = '0;
          state_d = (seen_q | ~game.led_go) ? S_DONE : S_ERROR;
        end
      end
      S_DONE: begin
        btn_d   = 1'b0;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        btn_d = 1'b0;
        if (!enable) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        btn_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      delay_q     <= '0;
      btn_q       <= 1'b0;
      seen_q      <= 1'b0;
      set_q       <= 1'b0;
      go_q        <= 1'b0;
      busy        <= 1'b0;
      trial_done  <= 1'b0;
      trial_count <= '0;
      latency_ms  <= '0;
      err         <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      delay_q    <= delay_d;
      btn_q      <= btn_d;
      seen_q     <= seen_d;
      set_q      <= game.led_set;
      go_q       <= game.led_go;
      latency_ms <= lat_d;
      // status flags decode the next state so they line up with state_q
      busy       <= (state_d != S_IDLE) && (state_d != S_ERROR);
      trial_done <= (state_d == S_DONE);
      err        <= (state_d == S_ERROR);
      if (state_d == S_DONE && trial_count != 8'hFF) begin
        trial_count <= trial_count + 1'b1;
      end
    end
  end

  assign game.btn = btn_q;

  // set_q is kept for symmetry with go_q; only the go edge drives a transition
  logic unused_set;
  assign unused_set = set_q;

endmodule

// File: tb/tb_reaction_responder.sv
// Self-checking bench for reaction_responder: a small game model answers the button,
// and expected latency, press widths and trial counts come from the timing rules.
module tb_reaction_responder;

  localparam int CLK_HZ        = 1000;
  localparam int TICK_HZ       = 100;
  localparam int DELAY_W       = 10;
  localparam int PRESS_TICKS   = 2;
  localparam int TIMEOUT_TICKS = 50;
  localparam int P             = CLK_HZ / TICK_HZ;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic [DELAY_W-1:0] react_ms = '0;
  logic               busy, trial_done, err;
  logic [7:0]         trial_count;
  logic [DELAY_W-1:0] latency_ms;

  int total = 0;
  int bad = 0;
  int exp_count = 0;

  reaction_responder_if gif ();

  reaction_responder #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DELAY_W(DELAY_W),
    .PRESS_TICKS(PRESS_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .react_ms(react_ms), .game(gif),
    .busy(busy), .trial_done(trial_done), .trial_count(trial_count),
    .latency_ms(latency_ms), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int sat_inc(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  // Game model: lights "set" on the start press, "go" after go_gap cycles,
  // and darkens both drop_gap cycles into the score press when ack is set.
  task automatic play_trial(input int react, input int go_gap, input int drop_gap, input bit ack,
                            output int start_w, output int go_lat, output bit done_seen,
                            output bit err_seen, output int done_w, output bit tmo);
    int n;
    tmo = 0; start_w = 0; go_lat = 0; done_seen = 0; err_seen = 0; done_w = 0;
    react_ms = DELAY_W'(react);
    enable = 1'b1;
    n = 0;
    while (gif.btn !== 1'b1 && n < 200) begin cyc(1); n++; end
    if (gif.btn !== 1'b1) begin tmo = 1; enable = 1'b0; return; end
    gif.led_set = 1'b1;
    start_w = 1;
    while (gif.btn === 1'b1 && start_w < 100) begin
      cyc(1);
      if (gif.btn === 1'b1) start_w++;
    end
    if (gif.btn === 1'b1) begin tmo = 1; enable = 1'b0; return; end
    cyc(go_gap);
    gif.led_go = 1'b1;
    while (gif.btn !== 1'b1 && go_lat < 2000) begin cyc(1); go_lat++; end
    if (gif.btn !== 1'b1) begin tmo = 1; enable = 1'b0; return; end
    if (ack) begin
      cyc(drop_gap);
      gif.led_set = 1'b0;
      gif.led_go = 1'b0;
    end
    n = 0;
    while (trial_done !== 1'b1 && err !== 1'b1 && n < 200) begin cyc(1); n++; end
    if (trial_done !== 1'b1 && err !== 1'b1) tmo = 1;
    done_seen = (trial_done === 1'b1);
    err_seen = (err === 1'b1);
    enable = 1'b0;
    if (done_seen) begin
      cyc(1);
      done_w = (trial_done === 1'b1) ? 2 : 1;
    end
    gif.led_set = 1'b0;
    gif.led_go = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(3);
    total++; if (gif.btn !== 1'b0) begin bad++; $display("FAIL rst_btn got %0b exp 0", gif.btn); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %0b exp 0", busy); end
    total++; if (trial_done !== 1'b0) begin bad++; $display("FAIL rst_done got %0b exp 0", trial_done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got %0b exp 0", err); end
    total++; if (trial_count !== 8'd0) begin bad++; $display("FAIL rst_count got %0d exp 0", trial_count); end
    total++; if (latency_ms !== '0) begin bad++; $display("FAIL rst_latency got %0d exp 0", latency_ms); end
    rst_n = 1'b1;
    cyc(5);
    total++; if (busy !== 1'b0 || gif.btn !== 1'b0) begin
      bad++; $display("FAIL idle_no_enable got busy=%0b btn=%0b exp 0/0", busy, gif.btn);
    end
  endtask

  task automatic check_good_trial(input string tag, input int react, input int sw, input int gl,
                                  input bit ds, input bit es, input int dw, input bit tmo);
    int lo, hi;
    lo = (react == 0) ? 2 : (react - 1) * P + 2;
    hi = (react == 0) ? 2 : react * P + 1;
    total++; if (tmo) begin bad++; $display("FAIL %s_timeout got stalled exp progress", tag); end
    total++; if (sw < (PRESS_TICKS - 1) * P + 1 || sw > PRESS_TICKS * P) begin
      bad++; $display("FAIL %s_start_width got %0d exp %0d..%0d", tag, sw, (PRESS_TICKS - 1) * P + 1, PRESS_TICKS * P);
    end
    total++; if (gl < lo || gl > hi) begin
      bad++; $display("FAIL %s_go_to_btn got %0d exp %0d..%0d", tag, gl, lo, hi);
    end
    total++; if (latency_ms !== DELAY_W'(react)) begin
      bad++; $display("FAIL %s_latency got %0d exp %0d", tag, latency_ms, react);
    end
    total++; if (!ds || es || dw != 1) begin
      bad++; $display("FAIL %s_done got done=%0b err=%0b width=%0d exp 1/0/1", tag, ds, es, dw);
    end
    total++; if (trial_count !== 8'(exp_count)) begin
      bad++; $display("FAIL %s_count got %0d exp %0d", tag, trial_count, exp_count);
    end
  endtask

  task automatic test_normal;
    int sw, gl, dw, r, g, d;
    bit ds, es, tmo;
    play_trial(5, 30, 3, 1'b1, sw, gl, ds, es, dw, tmo);
    exp_count = sat_inc(exp_count);
    check_good_trial("normal5", 5, sw, gl, ds, es, dw, tmo);
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 7);
      g = $urandom_range(1, 30);
      d = $urandom_range(1, 8);
      play_trial(r, g, d, 1'b1, sw, gl, ds, es, dw, tmo);
      exp_count = sat_inc(exp_count);
      check_good_trial("rand", r, sw, gl, ds, es, dw, tmo);
    end
  endtask

  task automatic test_zero_delay;
    int sw, gl, dw;
    bit ds, es, tmo;
    play_trial(4, 10, 2, 1'b1, sw, gl, ds, es, dw, tmo);
    exp_count = sat_inc(exp_count);
    check_good_trial("pre_zero", 4, sw, gl, ds, es, dw, tmo);
    play_trial(0, 7, 2, 1'b1, sw, gl, ds, es, dw, tmo);
    exp_count = sat_inc(exp_count);
    check_good_trial("zero", 0, sw, gl, ds, es, dw, tmo);
  endtask

  task automatic test_no_ack;
    int sw, gl, dw;
    bit ds, es, tmo;
    play_trial(2, 5, 0, 1'b0, sw, gl, ds, es, dw, tmo);
    total++; if (tmo || !es || ds) begin
      bad++; $display("FAIL no_ack got err=%0b done=%0b stall=%0b exp 1/0/0", es, ds, tmo);
    end
    total++; if (trial_count !== 8'(exp_count)) begin
      bad++; $display("FAIL no_ack_count got %0d exp %0d", trial_count, exp_count);
    end
    total++; if (err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL no_ack_recover got err=%0b busy=%0b exp 0/0", err, busy);
    end
  endtask

  task automatic test_timeout;
    int n;
    enable = 1'b1;
    react_ms = '0;
    n = 0;
    while (gif.btn !== 1'b1 && n < 200) begin cyc(1); n++; end
    gif.led_set = 1'b1;
    n = 0;
    while (gif.btn === 1'b1 && n < 200) begin cyc(1); n++; end
    n = 0;
    while (err !== 1'b1 && n < 1000) begin cyc(1); n++; end
    total++; if (n < (TIMEOUT_TICKS - 1) * P + 1 || n > TIMEOUT_TICKS * P) begin
      bad++; $display("FAIL timeout_cycles got %0d exp %0d..%0d", n, (TIMEOUT_TICKS - 1) * P + 1, TIMEOUT_TICKS * P);
    end
    cyc(3);
    total++; if (err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL timeout_sticky got err=%0b busy=%0b exp 1/0", err, busy);
    end
    enable = 1'b0;
    gif.led_set = 1'b0;
    cyc(2);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL timeout_clear got %0b exp 0", err); end
  endtask

  task automatic test_no_set;
    int n;
    enable = 1'b1;
    n = 0;
    while (gif.btn !== 1'b1 && n < 200) begin cyc(1); n++; end
    n = 0;
    while (gif.btn === 1'b1 && n < 200) begin cyc(1); n++; end
    total++; if (err !== 1'b1 || gif.btn !== 1'b0) begin
      bad++; $display("FAIL no_set got err=%0b btn=%0b exp 1/0", err, gif.btn);
    end
    enable = 1'b0;
    cyc(2);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL no_set_clear got %0b exp 0", err); end
  endtask

  task automatic test_reset_mid;
    int n;
    enable = 1'b1;
    react_ms = DELAY_W'(30);
    n = 0;
    while (gif.btn !== 1'b1 && n < 200) begin cyc(1); n++; end
    gif.led_set = 1'b1;
    n = 0;
    while (gif.btn === 1'b1 && n < 200) begin cyc(1); n++; end
    cyc(3);
    gif.led_go = 1'b1;
    cyc(20);
    total++; if (busy !== 1'b1 || gif.btn !== 1'b0) begin
      bad++; $display("FAIL react_state got busy=%0b btn=%0b exp 1/0", busy, gif.btn);
    end
    rst_n = 1'b0;
    #1;
    total++; if (gif.btn !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || trial_done !== 1'b0) begin
      bad++; $display("FAIL mid_rst_flags got btn=%0b busy=%0b err=%0b done=%0b exp 0", gif.btn, busy, err, trial_done);
    end
    total++; if (trial_count !== 8'd0 || latency_ms !== '0) begin
      bad++; $display("FAIL mid_rst_regs got count=%0d lat=%0d exp 0/0", trial_count, latency_ms);
    end
    exp_count = 0;
    gif.led_set = 1'b0;
    gif.led_go = 1'b0;
    enable = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    // second reset lands while btn is held in the score press
    enable = 1'b1;
    react_ms = '0;
    n = 0;
    while (gif.btn !== 1'b1 && n < 200) begin cyc(1); n++; end
    gif.led_set = 1'b1;
    n = 0;
    while (gif.btn === 1'b1 && n < 200) begin cyc(1); n++; end
    cyc(2);
    gif.led_go = 1'b1;
    n = 0;
    while (gif.btn !== 1'b1 && n < 200) begin cyc(1); n++; end
    cyc(2);
    total++; if (gif.btn !== 1'b1) begin bad++; $display("FAIL score_hold got %0b exp 1", gif.btn); end
    rst_n = 1'b0;
    #1;
    total++; if (gif.btn !== 1'b0) begin bad++; $display("FAIL async_btn_release got %0b exp 0", gif.btn); end
    gif.led_set = 1'b0;
    gif.led_go = 1'b0;
    enable = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_saturation;
    int sw, gl, dw, miss, cnt_err;
    bit ds, es, tmo;
    miss = 0;
    cnt_err = 0;
    for (int i = 0; i < 260; i++) begin
      play_trial(0, 2, 1, 1'b1, sw, gl, ds, es, dw, tmo);
      exp_count = sat_inc(exp_count);
      if (tmo || !ds || es || dw != 1) miss++;
      if (trial_count !== 8'(exp_count)) cnt_err++;
    end
    total++; if (miss != 0) begin bad++; $display("FAIL sat_pulses got %0d missing exp 0", miss); end
    total++; if (cnt_err != 0) begin bad++; $display("FAIL sat_track got %0d wrong counts exp 0", cnt_err); end
    total++; if (trial_count !== 8'd255) begin bad++; $display("FAIL sat_count got %0d exp 255", trial_count); end
  endtask

  initial begin
    gif.led_set = 1'b0;
    gif.led_go = 1'b0;
    test_reset();
    test_normal();
    test_zero_delay();
    test_no_ack();
    test_timeout();
    test_no_set();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end

endmodule
